// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: data accesses win over instruction fetches, with a
// starvation counter that forces a fetch grant after STARVE_MAX data grants.
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_ack,
    input  logic [31:0] m_rdata,
    output logic        busy
);

    localparam int unsigned CNT_W      = 4;
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE,
        MEM,
        RESP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] starve_cnt;
    logic             fetch_sel;
    logic             grant_fetch_c;
    logic             unused_addr_bits;

    // Fetch wins only when it is alone or has waited out its starvation budget.
    assign grant_fetch_c    = i_req && (!d_req || (starve_cnt == STARVE_LIM));
    assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            fetch_sel  <= 1'b0;
            m_req      <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            busy       <= 1'b0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        state <= MEM;
                        m_req <= 1'b1;
                        busy  <= 1'b1;
                        if (grant_fetch_c) begin
                            fetch_sel  <= 1'b1;
                            m_we       <= 1'b0;
                            m_addr     <= {i_addr[31:2], 2'b00};
                            m_wdata    <= '0;
                            starve_cnt <= '0;
                        end else begin
                            fetch_sel <= 1'b0;
                            m_we      <= d_we;
                            m_addr    <= {d_addr[31:2], 2'b00};
                            m_wdata   <= d_wdata;
                            if (i_req && (starve_cnt < STARVE_LIM))
                                starve_cnt <= CNT_W'(starve_cnt + CNT_W'(1));
                        end
                    end
                end
                MEM: begin
                    if (m_ack) begin
                        state <= RESP;
                        m_req <= 1'b0;
                        if (fetch_sel) begin
                            i_rdata <= m_rdata;
                            i_ack   <= 1'b1;
                        end else begin
                            d_ack <= 1'b1;
                            if (!m_we)
                                d_rdata <= m_rdata;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    m_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, store/fetch contention, starvation,
// long memory latency, reset mid-transaction and a spurious memory ack.
module tb_mem_arbiter;

    logic        sys_clk;
    logic        sys_rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ack;
    logic [31:0] m_rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.STARVE_MAX(4)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_ack   (i_ack),
        .i_rdata (i_rdata),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_ack   (d_ack),
        .d_rdata (d_rdata),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_ack   (m_ack),
        .m_rdata (m_rdata),
        .busy    (busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Advance one clock edge and settle just after it.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        sys_rst = 1'b1;
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        m_ack   = 1'b0;
        m_rdata = '0;
        tick();
        tick();
        check("rst_m_req", 32'(m_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_m_addr", m_addr, 32'd0);
        check("rst_acks", 32'({i_ack, d_ack, m_we}), 32'd0);
        check("rst_rdata", i_rdata | d_rdata | m_wdata, 32'd0);
        sys_rst = 1'b0;
        tick();

        // Lone fetch, zero-wait memory
        i_req  = 1'b1;
        i_addr = 32'h0000_0013;
        tick();
        check("fetch_m_req", 32'(m_req), 32'd1);
        check("fetch_m_addr", m_addr, 32'h0000_0010);
        check("fetch_m_we", 32'(m_we), 32'd0);
        check("fetch_m_wdata", m_wdata, 32'd0);
        check("fetch_busy", 32'(busy), 32'd1);
        m_ack   = 1'b1;
        m_rdata = 32'hCAFE_F00D;
        tick();
        check("fetch_i_ack", 32'(i_ack), 32'd1);
        check("fetch_d_ack", 32'(d_ack), 32'd0);
        check("fetch_i_rdata", i_rdata, 32'hCAFE_F00D);
        check("fetch_resp_m_req", 32'(m_req), 32'd0);
        check("fetch_resp_busy", 32'(busy), 32'd1);
        m_ack = 1'b0;
        i_req = 1'b0;
        tick();
        check("fetch_ack_pulse", 32'(i_ack), 32'd0);
        check("fetch_idle_busy", 32'(busy), 32'd0);

        // Spurious m_ack while idle
        m_ack   = 1'b1;
        m_rdata = 32'h1234_5678;
        tick();
        tick();
        check("spur_acks", 32'({i_ack, d_ack}), 32'd0);
        check("spur_busy", 32'(busy), 32'd0);
        check("spur_m_req", 32'(m_req), 32'd0);
        check("spur_i_rdata", i_rdata, 32'hCAFE_F00D);
        check("spur_d_rdata", d_rdata, 32'd0);
        m_ack = 1'b0;

        // Load with m_ack delayed 5 cycles
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h0000_0087;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("lat_m_req", 32'(m_req), 32'd1);
            check("lat_m_addr", m_addr, 32'h0000_0084);
            check("lat_busy", 32'(busy), 32'd1);
            check("lat_no_ack", 32'({i_ack, d_ack}), 32'd0);
            tick();
        end
        check("lat_m_req_last", 32'(m_req), 32'd1);
        m_ack   = 1'b1;
        m_rdata = 32'h1111_2222;
        tick();
        check("lat_d_ack", 32'(d_ack), 32'd1);
        check("lat_d_rdata", d_rdata, 32'h1111_2222);
        check("lat_resp_m_req", 32'(m_req), 32'd0);
        check("lat_resp_busy", 32'(busy), 32'd1);
        d_req = 1'b0;
        m_ack = 1'b0;
        tick();
        check("lat_ack_pulse", 32'(d_ack), 32'd0);

        // Simultaneous store and fetch: store first, then fetch
        i_req   = 1'b1;
        i_addr  = 32'h0000_0100;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h0000_0040;
        d_wdata = 32'hDEAD_BEEF;
        tick();
        check("both_m_we", 32'(m_we), 32'd1);
        check("both_m_addr", m_addr, 32'h0000_0040);
        check("both_m_wdata", m_wdata, 32'hDEAD_BEEF);
        m_ack   = 1'b1;
        m_rdata = 32'hFFFF_FFFF;
        tick();
        check("both_d_ack", 32'(d_ack), 32'd1);
        check("both_i_ack", 32'(i_ack), 32'd0);
        check("both_d_rdata_kept", d_rdata, 32'h1111_2222);
        m_ack = 1'b0;
        d_req = 1'b0;
        tick();
        tick();
        check("both_fetch_addr", m_addr, 32'h0000_0100);
        check("both_fetch_we", 32'(m_we), 32'd0);
        check("both_fetch_wdata", m_wdata, 32'd0);
        m_ack   = 1'b1;
        m_rdata = 32'h55AA_55AA;
        tick();
        check("both_fetch_i_ack", 32'(i_ack), 32'd1);
        check("both_fetch_i_rdata", i_rdata, 32'h55AA_55AA);
        check("both_fetch_d_ack", 32'(d_ack), 32'd0);
        m_ack = 1'b0;
        i_req = 1'b0;
        tick();

        // Starvation: four data grants, then the waiting fetch wins
        check("starve_start", 32'(dut.starve_cnt), 32'd0);
        i_req  = 1'b1;
        i_addr = 32'h0000_0300;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h0000_0200;
        for (int n = 0; n < 5; n++) begin
            tick();
            check("starve_m_addr", m_addr, (n < 4) ? 32'h0000_0200 : 32'h0000_0300);
            m_ack   = 1'b1;
            m_rdata = 32'(n);
            tick();
            check("starve_d_ack", 32'(d_ack), (n < 4) ? 32'd1 : 32'd0);
            check("starve_i_ack", 32'(i_ack), (n < 4) ? 32'd0 : 32'd1);
            check("starve_cnt", 32'(dut.starve_cnt), (n < 4) ? 32'(n + 1) : 32'd0);
            m_ack = 1'b0;
            if (n == 4)
                i_req = 1'b0;
            tick();
        end
        check("starve_d_rdata", d_rdata, 32'd3);
        check("starve_i_rdata", i_rdata, 32'd4);
        tick();
        check("starve_solo_addr", m_addr, 32'h0000_0200);
        m_ack = 1'b1;
        tick();
        check("starve_solo_ack", 32'(d_ack), 32'd1);
        check("starve_solo_cnt", 32'(dut.starve_cnt), 32'd0);
        m_ack = 1'b0;
        d_req = 1'b0;
        tick();

        // Reset two cycles after grant abandons the load
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h0000_0044;
        tick();
        check("rmid_m_req", 32'(m_req), 32'd1);
        tick();
        sys_rst = 1'b1;
        #1;
        check("rmid_m_req_drop", 32'(m_req), 32'd0);
        check("rmid_busy", 32'(busy), 32'd0);
        check("rmid_d_rdata", d_rdata, 32'd0);
        tick();
        check("rmid_no_ack", 32'({i_ack, d_ack}), 32'd0);
        sys_rst = 1'b0;
        tick();
        check("rmid_regrant", 32'(m_req), 32'd1);
        check("rmid_regrant_addr", m_addr, 32'h0000_0044);
        m_ack   = 1'b1;
        m_rdata = 32'hA5A5_0044;
        tick();
        check("rmid_d_ack", 32'(d_ack), 32'd1);
        check("rmid_load_rdata", d_rdata, 32'hA5A5_0044);
        m_ack = 1'b0;
        d_req = 1'b0;
        tick();
        check("rmid_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: consecutive data grants allowed while a fetch waits; legal range 1..15.
REQ-002 sys_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 sys_rst  in  1  reset, asynchronous, active-high.
REQ-004 i_req  in  1  instruction-fetch request; held high until i_ack.
REQ-005 i_addr  in  32  fetch byte address; stable while i_req high.
REQ-006 i_ack  out  1  one-cycle pulse: fetch complete, i_rdata valid.
REQ-007 i_rdata  out  32  fetched word; held until next fetch completion.
REQ-008 d_req  in  1  data-access request; held high until d_ack.
REQ-009 d_we  in  1  1 = store, 0 = load; stable while d_req high.
REQ-010 d_addr  in  32  data byte address; stable while d_req high.
REQ-011 d_wdata  in  32  store data; stable while d_req high.
REQ-012 d_ack  out  1  one-cycle pulse: data access complete.
REQ-013 d_rdata  out  32  load result; held until next load completion.
REQ-014 m_req  out  1  memory request; held until m_ack.
REQ-015 m_we  out  1  memory write enable, valid with m_req.
REQ-016 m_addr  out  32  word-aligned memory address, valid with m_req.
REQ-017 m_wdata  out  32  memory write data, valid with m_req and m_we.
REQ-018 m_ack  in  1  memory completion, variable latency >= 0 cycles after m_req rises.
REQ-019 m_rdata  in  32  read word, valid in the m_ack cycle.
REQ-020 busy  out  1  high in any state other than IDLE.

Function
REQ-021 FSM states IDLE, MEM, RESP; all outputs registered.
REQ-022 IDLE: no request -> stay; any request -> grant, register m_we/m_addr/m_wdata from granted port, go MEM.
REQ-023 Grant priority: data over fetch, except fetch wins when both pending and starve_cnt == STARVE_MAX.
REQ-024 starve_cnt, 4-bit: +1 on data grant with i_req high (saturate at STARVE_MAX); cleared on every fetch grant; held otherwise.
REQ-025 m_addr = {granted_addr[31:2], 2'b00}; fetch grants force m_we = 0, m_wdata = 0.
REQ-026 MEM: m_req = 1, m_* outputs constant; on m_ack capture m_rdata into granted port's rdata (loads and fetches only), go RESP.
REQ-027 Stores leave d_rdata unchanged.
REQ-028 RESP: granted port's ack = 1 for exactly this cycle, m_req = 0, go IDLE; requests not sampled in RESP.
REQ-029 Latency: request seen in IDLE cycle T -> m_req high from T+1 -> m_ack in cycle T+1+k -> ack in T+2+k; min 3 cycles request-to-ack edge.
REQ-030 A req still high in IDLE after its ack is a new request.
REQ-031 i_ack and d_ack never high together; at most one memory transaction outstanding.
REQ-032 m_ack outside MEM is ignored, no state change.
REQ-033 Requests arriving while busy wait; their addr/data are sampled only at grant.

Reset
REQ-034 sys_rst high: immediately state = IDLE, starve_cnt = 0, m_req = m_we = 0, m_addr = m_wdata = 0, i_ack = d_ack = 0, i_rdata = d_rdata = 0, busy = 0.
REQ-035 Reset during MEM or RESP abandons the transaction: no ack issued, rdata not updated; memory side tolerates the dropped m_req.
REQ-036 First grant possible in the first IDLE cycle after sys_rst deasserts.

Verification
REQ-037 Lone fetch: i_req, i_addr = 0x0000_0013, m_ack after 0 wait -> m_addr = 0x0000_0010, m_we = 0, i_ack 3 cycles later, i_rdata = m_rdata.
REQ-038 Simultaneous i_req + d_req (store 0xDEAD_BEEF to 0x40) -> data first with m_we = 1, m_wdata = 0xDEAD_BEEF, d_ack; then fetch granted; d_rdata unchanged.
REQ-039 Starvation: d_req held continuously, i_req high, STARVE_MAX = 4 -> exactly 4 data grants, then fetch granted, starve_cnt back to 0.
REQ-040 Variable latency: m_ack delayed 5 cycles -> m_req/m_addr stable all 5 cycles, ack exactly 1 cycle after m_ack, busy high throughout.
REQ-041 Reset mid-MEM: sys_rst pulsed 2 cycles after grant -> m_req drops same cycle, no ack, state IDLE; pending request regranted after release.
REQ-042 Spurious m_ack in IDLE -> no ack, no rdata change, state stays IDLE.
